// File: rtl/op_dispatch_if.sv
// Interface bundling the register-block request side, the engine handshake
// and the status bits of the operation dispatcher. The dispatcher takes the
// master view; the register block / engine side takes the slave view.
interface op_dispatch_if;
    // request capture from the register block
    logic        csr_op_en;
    logic [7:0]  csr_op_cmd;
    logic [7:0]  csr_op_param;
    logic [7:0]  csr_op_length;
    logic [11:0] csr_op_left;
    logic [11:0] csr_op_right;
    logic [11:0] csr_op_top;
    logic [11:0] csr_op_bottom;
    logic        op_flush;

    // engine handshake
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_cmd;
    logic [7:0]  op_param;
    logic [7:0]  op_length;
    logic [11:0] op_left;
    logic [11:0] op_right;
    logic [11:0] op_top;
    logic [11:0] op_bottom;
    logic        op_done;

    // status
    logic        op_busy;
    logic        op_queue;
    logic        op_full;
    logic        op_overflow;

    modport master (
        input  csr_op_en, csr_op_cmd, csr_op_param, csr_op_length,
        input  csr_op_left, csr_op_right, csr_op_top, csr_op_bottom,
        input  op_flush, op_ready, op_done,
        output op_valid, op_cmd, op_param, op_length,
        output op_left, op_right, op_top, op_bottom,
        output op_busy, op_queue, op_full, op_overflow
    );

    modport slave (
        output csr_op_en, csr_op_cmd, csr_op_param, csr_op_length,
        output csr_op_left, csr_op_right, csr_op_top, csr_op_bottom,
        output op_flush, op_ready, op_done,
        input  op_valid, op_cmd, op_param, op_length,
        input  op_left, op_right, op_top, op_bottom,
        input  op_busy, op_queue, op_full, op_overflow
    );
endinterface

// File: rtl/op_dispatch.sv
// Operation dispatcher: queues descriptors written by the register block in a
// small FIFO and hands them one at a time to the region-operation engine.
// A single outstanding operation is tracked by a two-state busy FSM.
module op_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic      clk,
    input  logic      rst,
    op_dispatch_if.master bus
);

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  param;
        logic [7:0]  length;
        logic [11:0] left;
        logic [11:0] right;
        logic [11:0] top;
        logic [11:0] bottom;
    } desc_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [AW:0]   C_CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

    // storage and queue state
    desc_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    state_t        r_state;

    // next-state values
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW:0]   w_count_nxt;
    logic          w_overflow_nxt;
    state_t        w_state_nxt;

    // decoded control
    desc_t w_wr_desc;
    desc_t w_head;
    logic  w_queue;
    logic  w_full;
    logic  w_busy;
    logic  w_valid;
    logic  w_pop;
    logic  w_push;
    logic  w_drop;
    logic  w_flush;

    assign w_flush = bus.op_flush;
    assign w_queue = (r_count != C_CNT_ZERO);
    assign w_full  = (r_count == C_CNT_FULL);

    // Flush masks the offer so nothing is issued while the queue is dropped;
    // a push is accepted when full only if the head leaves in the same cycle.
    assign w_valid = w_queue && !w_busy && !w_flush;
    assign w_pop   = w_valid && bus.op_ready;
    assign w_push  = bus.csr_op_en && !w_flush && (!w_full || w_pop);
    assign w_drop  = bus.csr_op_en && !w_flush && w_full && !w_pop;

    assign w_wr_desc = '{
        cmd:    bus.csr_op_cmd,
        param:  bus.csr_op_param,
        length: bus.csr_op_length,
        left:   bus.csr_op_left,
        right:  bus.csr_op_right,
        top:    bus.csr_op_top,
        bottom: bus.csr_op_bottom
    };

    // Head entry is read asynchronously so the engine sees it in the offer cycle.
    assign w_head = r_mem[r_rd_ptr];

    // Descriptor array write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_desc;
        end
    end

    // Next pointer, occupancy and sticky-overflow values; flush wins over push/pop.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        if (w_flush) begin
            w_rd_ptr_nxt   = r_wr_ptr;
            w_count_nxt    = C_CNT_ZERO;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + C_PTR_ONE;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + C_PTR_ONE;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + C_CNT_ONE;
                2'b01:   w_count_nxt = r_count - C_CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
            if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_overflow_nxt = r_overflow;
            end
        end
    end

    // Queue state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= C_CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Busy FSM state register; reset abandons any outstanding operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Busy FSM next state: issue enters BUSY, op_done returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.op_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Busy FSM output decode.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_IDLE: w_busy = 1'b0;
            ST_BUSY: w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    assign bus.op_valid    = w_valid;
    assign bus.op_cmd      = w_head.cmd;
    assign bus.op_param    = w_head.param;
    assign bus.op_length   = w_head.length;
    assign bus.op_left     = w_head.left;
    assign bus.op_right    = w_head.right;
    assign bus.op_top      = w_head.top;
    assign bus.op_bottom   = w_head.bottom;
    assign bus.op_busy     = w_busy;
    assign bus.op_queue    = w_queue;
    assign bus.op_full     = w_full;
    assign bus.op_overflow = r_overflow;

endmodule

// File: tb/tb_op_dispatch.sv
// Self-checking bench for op_dispatch: a scoreboard queue holds descriptors
// the bench expects to be issued, and a negedge monitor checks each issue.
module tb_op_dispatch;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  param;
        logic [7:0]  length;
        logic [11:0] left;
        logic [11:0] right;
        logic [11:0] top;
        logic [11:0] bottom;
    } desc_t;

    logic clk;
    logic rst;
    op_dispatch_if bus();

    int total;
    int bad;
    desc_t sb[$];

    op_dispatch #(.DEPTH(4), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every issue must match the oldest expected descriptor.
    always @(negedge clk) begin
        desc_t act;
        desc_t exp;
        if (!rst && bus.op_valid === 1'b1 && bus.op_ready === 1'b1) begin
            act = '{cmd: bus.op_cmd, param: bus.op_param, length: bus.op_length,
                    left: bus.op_left, right: bus.op_right,
                    top: bus.op_top, bottom: bus.op_bottom};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got cmd=%h, required no issue", act.cmd);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL issue_fields: got %h, required %h", act, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one strobe; accepted descriptors enter the scoreboard.
    task automatic push(input logic [7:0] cmd, input logic [11:0] left,
                        input logic [11:0] right, input bit accept);
        desc_t d;
        d.cmd    = cmd;
        d.param  = cmd ^ 8'hA5;
        d.length = cmd + 8'd3;
        d.left   = left;
        d.right  = right;
        d.top    = {4'h1, cmd};
        d.bottom = {4'h2, ~cmd};
        bus.csr_op_cmd    = d.cmd;
        bus.csr_op_param  = d.param;
        bus.csr_op_length = d.length;
        bus.csr_op_left   = d.left;
        bus.csr_op_right  = d.right;
        bus.csr_op_top    = d.top;
        bus.csr_op_bottom = d.bottom;
        bus.csr_op_en     = 1'b1;
        tick();
        bus.csr_op_en     = 1'b0;
        if (accept) sb.push_back(d);
    endtask

    // Engine model: wait for each issue (bounded) then pulse op_done.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (bus.op_busy !== 1'b1 && t < 20) begin
                tick();
                t++;
            end
            if (bus.op_busy !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: op_busy=%b after %0d cycles, required 1", bus.op_busy, t);
            end
            bus.op_done = 1'b1;
            tick();
            bus.op_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total += 5;
        if (bus.op_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid: got %b, required 0", bus.op_valid); end
        if (bus.op_busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b, required 0", bus.op_busy); end
        if (bus.op_queue !== 1'b0)    begin bad++; $display("FAIL rst_queue: got %b, required 0", bus.op_queue); end
        if (bus.op_full !== 1'b0)     begin bad++; $display("FAIL rst_full: got %b, required 0", bus.op_full); end
        if (bus.op_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b, required 0", bus.op_overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.op_ready = 1'b1;
        push(8'h12, 12'h010, 12'h0FF, 1'b1);
        total += 2;
        if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL single_valid_latency: got %b, required 1", bus.op_valid); end
        if (bus.op_cmd !== 8'h12)  begin bad++; $display("FAIL single_cmd: got %h, required 12", bus.op_cmd); end
        tick();
        total += 3;
        if (bus.op_busy !== 1'b1)  begin bad++; $display("FAIL single_busy: got %b, required 1", bus.op_busy); end
        if (bus.op_queue !== 1'b0) begin bad++; $display("FAIL single_queue: got %b, required 0", bus.op_queue); end
        if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL single_valid_busy: got %b, required 0", bus.op_valid); end
        drain(1);
        total++;
        if (bus.op_busy !== 1'b0)  begin bad++; $display("FAIL single_done: got %b, required 0", bus.op_busy); end
    endtask

    task automatic test_overflow();
        bus.op_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i), 12'(i * 16), 12'(i * 32), 1'b1);
        total += 3;
        if (bus.op_full !== 1'b1)     begin bad++; $display("FAIL ovf_full: got %b, required 1", bus.op_full); end
        if (bus.op_queue !== 1'b1)    begin bad++; $display("FAIL ovf_queue: got %b, required 1", bus.op_queue); end
        if (bus.op_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b, required 0", bus.op_overflow); end
        push(8'h05, 12'h050, 12'h0A0, 1'b0);
        total += 2;
        if (bus.op_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", bus.op_overflow); end
        if (bus.op_full !== 1'b1)     begin bad++; $display("FAIL ovf_still_full: got %b, required 1", bus.op_full); end
        bus.op_ready = 1'b1;
        drain(4);
        total += 3;
        if (sb.size() != 0)           begin bad++; $display("FAIL ovf_drained: got %0d pending, required 0", sb.size()); end
        if (bus.op_queue !== 1'b0)    begin bad++; $display("FAIL ovf_queue_empty: got %b, required 0", bus.op_queue); end
        if (bus.op_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", bus.op_overflow); end
    endtask

    task automatic test_full_push_pop();
        bus.op_flush = 1'b1;
        tick();
        bus.op_flush = 1'b0;
        total++;
        if (bus.op_overflow !== 1'b0) begin bad++; $display("FAIL fpp_flush_ovf: got %b, required 0", bus.op_overflow); end
        bus.op_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(8'h20 + i), 12'h100, 12'h200, 1'b1);
        bus.op_ready = 1'b1;
        push(8'h09, 12'h090, 12'h099, 1'b1);
        total += 3;
        if (bus.op_overflow !== 1'b0) begin bad++; $display("FAIL fpp_no_ovf: got %b, required 0", bus.op_overflow); end
        if (bus.op_full !== 1'b1)     begin bad++; $display("FAIL fpp_full: got %b, required 1", bus.op_full); end
        if (bus.op_busy !== 1'b1)     begin bad++; $display("FAIL fpp_busy: got %b, required 1", bus.op_busy); end
        drain(5);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL fpp_drained: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        bus.op_ready = 1'b1;
        push(8'h31, 12'h001, 12'h002, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 2) push(8'(8'h32 + i), 12'h003, 12'h004, 1'b1);
            else tick();
            total++;
            if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL b2b_hold_valid: cycle %0d got %b, required 0", i, bus.op_valid); end
        end
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        total += 2;
        if (bus.op_busy !== 1'b0)  begin bad++; $display("FAIL b2b_busy_clear: got %b, required 0", bus.op_busy); end
        if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL b2b_revalid: got %b, required 1", bus.op_valid); end
        drain(2);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_drained: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_flush();
        bus.op_ready = 1'b1;
        push(8'h41, 12'h011, 12'h022, 1'b1);
        tick();
        bus.op_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'h42 + i), 12'h033, 12'h044, 1'b1);
        total += 2;
        if (bus.op_queue !== 1'b1) begin bad++; $display("FAIL flush_pre_queue: got %b, required 1", bus.op_queue); end
        if (bus.op_busy !== 1'b1)  begin bad++; $display("FAIL flush_pre_busy: got %b, required 1", bus.op_busy); end
        bus.op_flush   = 1'b1;
        bus.op_ready   = 1'b1;
        bus.csr_op_cmd = 8'h77;
        bus.csr_op_en  = 1'b1;
        tick();
        bus.op_flush  = 1'b0;
        bus.csr_op_en = 1'b0;
        sb.delete();
        total += 5;
        if (bus.op_queue !== 1'b0)    begin bad++; $display("FAIL flush_queue: got %b, required 0", bus.op_queue); end
        if (bus.op_full !== 1'b0)     begin bad++; $display("FAIL flush_full: got %b, required 0", bus.op_full); end
        if (bus.op_overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf: got %b, required 0", bus.op_overflow); end
        if (bus.op_busy !== 1'b1)     begin bad++; $display("FAIL flush_busy_kept: got %b, required 1", bus.op_busy); end
        if (bus.op_valid !== 1'b0)    begin bad++; $display("FAIL flush_valid: got %b, required 0", bus.op_valid); end
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        total += 2;
        if (bus.op_busy !== 1'b0)  begin bad++; $display("FAIL flush_done_busy: got %b, required 0", bus.op_busy); end
        if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid: got %b, required 0", bus.op_valid); end
        tick();
        total++;
        if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_valid: got %b, required 0", bus.op_valid); end
    endtask

    task automatic test_reset_mid();
        bus.op_ready = 1'b1;
        push(8'h51, 12'h0AA, 12'h0BB, 1'b1);
        tick();
        bus.op_ready = 1'b0;
        push(8'h52, 12'h0CC, 12'h0DD, 1'b1);
        push(8'h53, 12'h0EE, 12'h0FF, 1'b1);
        total++;
        if (bus.op_busy !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy: got %b, required 1", bus.op_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        total += 5;
        if (bus.op_valid !== 1'b0)    begin bad++; $display("FAIL rmid_valid: got %b, required 0", bus.op_valid); end
        if (bus.op_busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy: got %b, required 0", bus.op_busy); end
        if (bus.op_queue !== 1'b0)    begin bad++; $display("FAIL rmid_queue: got %b, required 0", bus.op_queue); end
        if (bus.op_full !== 1'b0)     begin bad++; $display("FAIL rmid_full: got %b, required 0", bus.op_full); end
        if (bus.op_overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf: got %b, required 0", bus.op_overflow); end
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        total += 2;
        if (bus.op_busy !== 1'b0)  begin bad++; $display("FAIL rmid_stray_done: got %b, required 0", bus.op_busy); end
        if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL rmid_stray_valid: got %b, required 0", bus.op_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst               = 1'b1;
        bus.csr_op_en     = 1'b0;
        bus.csr_op_cmd    = 8'h00;
        bus.csr_op_param  = 8'h00;
        bus.csr_op_length = 8'h00;
        bus.csr_op_left   = 12'h000;
        bus.csr_op_right  = 12'h000;
        bus.csr_op_top    = 12'h000;
        bus.csr_op_bottom = 12'h000;
        bus.op_flush      = 1'b0;
        bus.op_ready      = 1'b0;
        bus.op_done       = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/op_dispatch.md
Name: op_dispatch

Overview:
- Sits directly downstream of the SPI control/status register block.
- Captures each operation request (the single-cycle csr_op_en strobe plus the op command, param, length and rectangle fields) into a small descriptor FIFO.
- Issues one descriptor at a time to the region-operation engine over a valid/ready handshake, and tracks engine completion.
- Produces the op_busy and op_queue status bits that the register block reports in its STATUS register.

Parameters:
- DEPTH, 4, number of queued descriptors; power of 2, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- csr_op_en  in  1  one-cycle push strobe from the register block.
- csr_op_cmd  in  8  operation command.
- csr_op_param  in  8  operation parameter.
- csr_op_length  in  8  operation length.
- csr_op_left  in  12  rectangle left.
- csr_op_right  in  12  rectangle right.
- csr_op_top  in  12  rectangle top.
- csr_op_bottom  in  12  rectangle bottom.
- op_flush  in  1  drop all queued (not yet issued) descriptors.
- op_valid  out  1  head descriptor is offered to the engine.
- op_ready  in  1  engine accepts the offered descriptor.
- op_cmd, op_param, op_length  out  8 each  head descriptor fields.
- op_left, op_right, op_top, op_bottom  out  12 each  head descriptor fields.
- op_done  in  1  one-cycle pulse: engine finished the issued operation.
- op_busy  out  1  an issued operation has not yet completed.
- op_queue  out  1  FIFO holds at least one descriptor.
- op_full  out  1  FIFO holds DEPTH descriptors.
- op_overflow  out  1  sticky: a push was dropped.

Behaviour:
- Descriptor: 72 bits (cmd, param, length, left, right, top, bottom). Stored in a DEPTH-entry array written at wr_ptr.
- Head read is asynchronous from rd_ptr; op_* field outputs are combinational from the head entry. Field values are don't-care while op_valid=0.
- Pointers are AW bits and wrap modulo DEPTH. count is AW+1 bits, range 0..DEPTH.
  - op_queue = (count != 0).
  - op_full = (count == DEPTH).
- Push: csr_op_en=1 and (count < DEPTH or pop in the same cycle).
  - Writes the entry, increments wr_ptr.
  - Push into an empty queue gives op_valid=1 in the cycle after the strobe (latency 1).
- Drop: csr_op_en=1 while full and no pop in the same cycle. Entry is discarded, op_overflow is set; no other state changes.
- Offer: op_valid = op_queue && !op_busy. Only one operation is outstanding at a time.
- Pop/issue: op_valid && op_ready at a clock edge.
  - rd_ptr increments and op_busy is set at that edge.
  - The fields are captured by the engine in that same cycle.
- Simultaneous push and pop: count is unchanged. This is allowed even when full, and even when count==1 (next head = new entry).
- Completion: op_done while op_busy clears op_busy at that edge. Next op_valid can assert in the following cycle, giving a minimum 1 idle cycle between issues. op_done while !op_busy is ignored.
- op_done and a new issue cannot coincide, because op_valid requires !op_busy.
- op_flush=1:
  - Sets rd_ptr = wr_ptr, count=0, op_overflow=0.
  - op_busy is unaffected; a running operation still completes via op_done.
  - Flush has priority over push and pop in the same cycle: the push is discarded without setting overflow, and no issue occurs because op_valid is forced 0 during flush.
- Reset: rst has priority over everything.
  - Outputs at reset: op_valid=0, op_busy=0, op_queue=0, op_full=0, op_overflow=0; pointers=0, count=0.
  - Array contents are not reset.
  - Reset mid-operation abandons the outstanding op; a later op_done is ignored.
- op_overflow clears only on rst or op_flush.

Test Plan:
- Push cmd=0x12, left=0x010, right=0x0FF, op_ready=1 -> op_valid=1 one cycle after strobe with matching fields; op_busy=1 next cycle; op_queue=0 after pop.
- op_ready=0, push 4 descriptors (cmd 1..4) -> op_full=1, op_queue=1; 5th push (cmd 5) -> op_overflow=1, count stays 4; then op_ready=1 with op_done after each -> cmds issued 1,2,3,4 in order.
- Full queue, op_ready=1 and push cmd=9 in the same cycle -> push accepted, no overflow, cmd 9 later issued fifth.
- Issue an op, hold op_done low 10 cycles while pushing 2 more -> op_valid stays 0 until op_done; re-asserts exactly 1 cycle after op_done.
- Queue 3 entries with op_busy=1, assert op_flush together with csr_op_en -> count=0, op_queue=0, op_overflow=0, op_busy still 1; subsequent op_done clears op_busy, op_valid stays 0.
- Assert rst while op_busy=1 and count=2 -> all outputs 0 next cycle; stray op_done afterwards leaves op_busy=0.
